// File: rtl/ordering_tx.sv
// Reads one replica's city ordering from RAM and streams it as 64-bit words, 8 cities per word.
// Latency: start -> first word valid 10 cycles later. Backpressure: ordering_read low holds the output word; at most one further word is assembled.
module ordering_tx #(
    parameter  int NCITY    = 31,
    parameter  int NREPLICA = 32,
    localparam int CW       = $clog2(NCITY),
    localparam int RW       = $clog2(NREPLICA)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [RW-1:0]        replica_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_re,
    output logic [RW+CW-1:0]     ram_raddr,
    input  logic [7:0]           ram_rdata,
    input  logic                 ordering_read,
    output logic                 ordering_ready,
    output logic [7:0][7:0]      ordering_rdata
);

    localparam int NFULL = NCITY / 8;
    localparam int NREM  = NCITY % 8;
    localparam int NWORD = NFULL + 1;
    localparam int WW    = $clog2(NWORD + 1);
    localparam logic [WW-1:0] LAST_W = WW'(NWORD - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_LAND, S_PUSH, S_DRAIN} state_t;

    function automatic logic [3:0] word_cnt(input logic [WW-1:0] w);
        return (int'(w) < NFULL) ? 4'd8 : 4'(NREM);
    endfunction

    state_t            r_state;
    logic [RW-1:0]     r_rep;
    logic [WW-1:0]     r_word;
    logic [CW-1:0]     r_city;
    logic [3:0]        r_j;
    logic              r_ram_re;
    logic [RW+CW-1:0]  r_ram_raddr;
    logic              r_rd_vld;
    logic [2:0]        r_rd_slot;
    logic [7:0][7:0]   r_asm;
    logic              r_asm_full;
    logic [7:0][7:0]   r_out;
    logic              r_out_full;
    logic              r_out_last;
    logic              r_done;

    logic              w_xfer;
    logic              w_out_free;
    logic              w_move;
    logic [WW-1:0]     w_nxt_word;
    logic [7:0][7:0]   w_asm_cap;

    assign w_xfer     = r_out_full & ordering_read;
    assign w_out_free = !r_out_full || w_xfer;
    assign w_move     = w_out_free && ((r_state == S_LAND) || (r_state == S_PUSH && r_asm_full));
    assign w_nxt_word = r_word + WW'(1);

    // Low address bits equal the byte slot, so returning data lands without a separate tag.
    always_comb begin
        w_asm_cap = r_asm;
        if (r_rd_vld) w_asm_cap[3'd7 - r_rd_slot] = ram_rdata;
    end

    assign ordering_ready = w_xfer;
    assign ordering_rdata = r_out;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign ram_re         = r_ram_re;
    assign ram_raddr      = r_ram_raddr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_rep       <= '0;
            r_word      <= '0;
            r_city      <= '0;
            r_j         <= '0;
            r_ram_re    <= 1'b0;
            r_ram_raddr <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_slot   <= '0;
            r_asm       <= '0;
            r_asm_full  <= 1'b0;
            r_out       <= '0;
            r_out_full  <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_rd_vld  <= r_ram_re;
            r_rd_slot <= r_ram_raddr[2:0];
            r_asm     <= w_asm_cap;
            if (w_xfer) r_out_full <= 1'b0;
            if (w_move) begin
                r_out      <= w_asm_cap;
                r_out_full <= 1'b1;
                r_out_last <= (r_word == LAST_W);
                r_asm      <= '0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rep       <= replica_sel;
                        r_word      <= '0;
                        r_asm       <= '0;
                        r_asm_full  <= 1'b0;
                        r_ram_re    <= 1'b1;
                        r_ram_raddr <= {replica_sel, {CW{1'b0}}};
                        r_city      <= CW'(1);
                        r_j         <= 4'd1;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (r_j < word_cnt(r_word)) begin
                        r_ram_raddr <= {r_rep, r_city};
                        r_city      <= r_city + CW'(1);
                        r_j         <= r_j + 4'd1;
                    end else begin
                        r_ram_re <= 1'b0;
                        r_state  <= S_LAND;
                    end
                end
                S_LAND: begin
                    r_asm_full <= !w_out_free;
                    r_state    <= S_PUSH;
                end
                S_PUSH: begin
                    if (!r_asm_full || w_out_free) begin
                        r_asm_full <= 1'b0;
                        if (r_word == LAST_W) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_word <= w_nxt_word;
                            // A city count that is a multiple of 8 still ends with an empty word.
                            if (word_cnt(w_nxt_word) == 4'd0) begin
                                r_asm_full <= 1'b1;
                            end else begin
                                r_ram_re    <= 1'b1;
                                r_ram_raddr <= {r_rep, r_city};
                                r_city      <= r_city + CW'(1);
                                r_j         <= 4'd1;
                                r_state     <= S_FILL;
                            end
                        end
                    end
                end
                default: ;
            endcase
            if (w_xfer && r_out_last) begin
                r_out_last <= 1'b0;
                r_done     <= 1'b1;
                r_state    <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ordering_tx.sv
// Self-checking bench for ordering_tx: vector table of read-out runs plus reset and 32-city corner cases.
module tb_ordering_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            a_start, a_read, a_busy, a_done, a_re, a_ready;
    logic [4:0]      a_rep;
    logic [9:0]      a_raddr;
    logic [7:0]      a_ram_q = 8'h00;
    logic [7:0][7:0] a_rdata;
    logic            b_start, b_read, b_busy, b_done, b_re, b_ready;
    logic [4:0]      b_rep;
    logic [9:0]      b_raddr;
    logic [7:0]      b_ram_q = 8'h00;
    logic [7:0][7:0] b_rdata;

    ordering_tx #(.NCITY(31), .NREPLICA(32)) u_a (
        .clk(clk), .reset(reset_n), .start(a_start), .replica_sel(a_rep),
        .busy(a_busy), .done(a_done), .ram_re(a_re), .ram_raddr(a_raddr),
        .ram_rdata(a_ram_q), .ordering_read(a_read), .ordering_ready(a_ready),
        .ordering_rdata(a_rdata)
    );

    ordering_tx #(.NCITY(32), .NREPLICA(32)) u_b (
        .clk(clk), .reset(reset_n), .start(b_start), .replica_sel(b_rep),
        .busy(b_busy), .done(b_done), .ram_re(b_re), .ram_raddr(b_raddr),
        .ram_rdata(b_ram_q), .ordering_read(b_read), .ordering_ready(b_ready),
        .ordering_rdata(b_rdata)
    );

    // RAM content: low 3 replica bits in [7:5], city number in [4:0].
    function automatic logic [7:0] ram_val(input logic [9:0] addr);
        return addr[7:0];
    endfunction

    always @(posedge clk) begin
        if (a_re) a_ram_q <= ram_val(a_raddr);
        if (b_re) b_ram_q <= ram_val(b_raddr);
    end

    function automatic logic [63:0] exp_word(input logic [4:0] rep, input int w, input int ncity);
        logic [63:0] e;
        int k;
        logic [4:0] kk;
        e = '0;
        for (int j = 0; j < 8; j++) begin
            k  = w * 8 + j;
            kk = k[4:0];
            if (k < ncity) e[8*(7-j) +: 8] = {rep[2:0], kk};
        end
        return e;
    endfunction

    typedef struct {
        logic [4:0] rep;
        int         mode;   // 0 read high, 1 toggle, 2 low 50 cycles, 3 start again while busy
        int         words;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int a_reads = 0, a_rdy_cnt = 0, a_done_cnt = 0, first_rdy = -1, last_rdy = 0;
    int b_rdy_cnt = 0, b_done_cnt = 0, b_last_rdy = 0;
    logic [4:0]  exp_rep = 5'd0;
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    vec_t        vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        if (reset_n) begin
            if (a_re) begin
                a_reads++;
                check("raddr_replica", 64'(a_raddr[9:5]), 64'(exp_rep));
            end
            if (a_ready) begin
                a_rdy_cnt++;
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_word_a: got %h expected none", a_rdata);
                end else check("word_a", a_rdata, qa.pop_front());
                last_rdy = cyc;
                if (first_rdy < 0) first_rdy = cyc;
            end
            if (a_done) begin
                a_done_cnt++;
                check("done_a_timing", 64'(cyc), 64'(last_rdy + 1));
            end
            if (b_ready) begin
                b_rdy_cnt++;
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_word_b: got %h expected none", b_rdata);
                end else check("word_b", b_rdata, qb.pop_front());
                b_last_rdy = cyc;
            end
            if (b_done) begin
                b_done_cnt++;
                check("done_b_timing", 64'(cyc), 64'(b_last_rdy + 1));
            end
        end
    endtask

    // Samples the current cycle on the falling edge, then returns 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int r0, d0, rd0, t0;
        exp_rep = v.rep;
        for (int w = 0; w < 4; w++) qa.push_back(exp_word(v.rep, w, 31));
        r0 = a_rdy_cnt; d0 = a_done_cnt; rd0 = a_reads; first_rdy = -1;
        a_read  = (v.mode == 0 || v.mode == 3);
        a_rep   = v.rep;
        a_start = 1'b1;
        t0 = cyc;
        for (int c = 0; c < 400; c++) begin
            tick();
            a_start = 1'b0;
            if (a_done_cnt != d0) break;
            case (v.mode)
                1:       a_read = 1'((c + 1) % 2);
                2:       a_read = (c + 1 >= 50);
                default: a_read = 1'b1;
            endcase
            if (v.mode == 3 && c == 2) begin
                a_start = 1'b1;
                a_rep   = 5'd9;
            end
            if (v.mode == 2 && c == 49) begin
                check("stall_no_ready", 64'(a_rdy_cnt - r0), 64'd0);
                check("stall_read_count", 64'(a_reads - rd0), 64'd16);
            end
        end
        check("done_count", 64'(a_done_cnt - d0), 64'd1);
        check("ready_count", 64'(a_rdy_cnt - r0), 64'(v.words));
        check("queue_empty", 64'(qa.size()), 64'd0);
        check("busy_after", 64'(a_busy), 64'd0);
        if (v.mode == 0 || v.mode == 3)
            check("first_word_latency", 64'(first_rdy - t0), 64'd10);
        a_read = 1'b1;
        qa.delete();
    endtask

    initial begin
        int r0, d0;
        vecs[0] = '{5'd0,  0, 4};
        vecs[1] = '{5'd5,  3, 4};
        vecs[2] = '{5'd0,  2, 4};
        vecs[3] = '{5'd31, 1, 4};
        vecs[4] = '{5'd7,  0, 4};

        reset_n = 1'b0;
        a_start = 1'b0; a_read = 1'b1; a_rep = '0;
        b_start = 1'b0; b_read = 1'b1; b_rep = '0;
        repeat (3) tick();
        check("rst_busy",   64'(a_busy),  64'd0);
        check("rst_done",   64'(a_done),  64'd0);
        check("rst_ram_re", 64'(a_re),    64'd0);
        check("rst_raddr",  64'(a_raddr), 64'd0);
        check("rst_ready",  64'(a_ready), 64'd0);
        check("rst_rdata",  a_rdata,      64'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
            repeat (3) tick();
        end

        // Reset while word 2 is being assembled.
        exp_rep = 5'd0;
        for (int w = 0; w < 4; w++) qa.push_back(exp_word(5'd0, w, 31));
        r0 = a_rdy_cnt; d0 = a_done_cnt;
        a_rep = 5'd0; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (a_rdy_cnt - r0 >= 2) break;
            tick();
        end
        check("reached_word2", 64'(a_rdy_cnt - r0), 64'd2);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy",   64'(a_busy),  64'd0);
        check("mid_rst_ram_re", 64'(a_re),    64'd0);
        check("mid_rst_raddr",  64'(a_raddr), 64'd0);
        check("mid_rst_ready",  64'(a_ready), 64'd0);
        check("mid_rst_rdata",  a_rdata,      64'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        qa.delete();
        tick();
        check("no_done_on_reset", 64'(a_done_cnt - d0), 64'd0);
        run_vec(vecs[0]);

        // 32-city build: four full words and a trailing all-zero word.
        for (int w = 0; w < 5; w++) qb.push_back(exp_word(5'd0, w, 32));
        d0 = b_done_cnt; r0 = b_rdy_cnt;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (b_done_cnt != d0) break;
            tick();
        end
        check("b_done_count",  64'(b_done_cnt - d0), 64'd1);
        check("b_ready_count", 64'(b_rdy_cnt - r0),  64'd5);
        check("b_queue_empty", 64'(qb.size()),       64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
